// File: rtl/matriz_varredura_linhas_pkg.sv
// Purpose: shared types and sizes for the 5x7 matrix row-scan driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matriz_varredura_linhas_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam int N_LIN   = 7;
    localparam int N_COL   = 5;
    localparam int FRAME_W = N_LIN * N_COL;
    localparam int ROW_W   = 3;

endpackage

// File: rtl/matriz_varredura_linhas_divisor_tick.sv
// Purpose: scan-tick prescaler; counts 0..TICK_DIV-1 and flags the last count.
// Latency: tick is a combinational decode of the counter; counter is held at 0 by clear_i.
// Backpressure: none; free-running while clear_i is low.
module matriz_varredura_linhas_divisor_tick #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign tick_o = (presc_q == PW'(TICK_DIV - 1));

    // Next count: cleared while idle, wraps to 0 on tick, else increments.
    always_comb begin
        presc_d = presc_q;
        if (clear_i) begin
            presc_d = '0;
        end else if (tick_o) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/matriz_varredura_linhas.sv
// Purpose: captures a 35-bit frame into a shadow buffer and scans it row by row with a blank gap.
// Latency: row 0 lights TICK_DIV+1 cycles after enable is sampled in IDLE; all outputs registered.
// Backpressure: none; enable is a level, a running frame always completes through row 6.
module matriz_varredura_linhas
    import matriz_varredura_linhas_pkg::*;
#(
    parameter int TICK_DIV   = 1000,
    parameter int SHOW_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [FRAME_W-1:0] frame_in,
    output logic [N_LIN-1:0]   lin,
    output logic [N_COL-1:0]   col,
    output logic               busy,
    output logic               frame_done
);

    localparam int TW = (SHOW_TICKS > 2) ? $clog2(SHOW_TICKS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_LIN - 1);

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;

    logic [N_LIN-1:0]   lin_q, lin_d;
    logic [N_COL-1:0]   col_q, col_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               tick;
    logic               last_tick;

    matriz_varredura_linhas_divisor_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_divisor_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (state_q == IDLE),
        .tick_o  (tick)
    );

    assign last_tick = tick && (tcnt_q == TW'(SHOW_TICKS - 1));

    // Next-state logic: frame capture, blank/show sequencing, row advance and frame wrap.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        tcnt_d   = tcnt_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    shadow_d = frame_in;
                    row_d    = '0;
                    state_d  = BLANK;
                end
            end
            BLANK: begin
                if (tick) begin
                    tcnt_d  = '0;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (last_tick) begin
                    if (row_q < LAST_ROW) begin
                        row_d   = row_q + 1'b1;
                        state_d = BLANK;
                    end else begin
                        // Frame boundary: the only place the shadow reloads and row wraps.
                        done_d = 1'b1;
                        row_d  = '0;
                        if (enable) begin
                            shadow_d = frame_in;
                            state_d  = BLANK;
                        end else begin
                            state_d  = IDLE;
                        end
                    end
                end else if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
            end
        endcase
    end

    // Output decode: one-hot row select and column slice only while showing.
    always_comb begin
        lin_d  = '0;
        col_d  = '0;
        busy_d = (state_d != IDLE);
        if (state_q == SHOW) begin
            for (int i = 0; i < N_LIN; i++) begin
                lin_d[i] = (row_q == ROW_W'(i));
            end
            col_d = shadow_q[N_COL*row_q +: N_COL];
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            tcnt_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            tcnt_q   <= tcnt_d;
            shadow_q <= shadow_d;
        end
    end

    // Registered pin drivers so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lin_q  <= '0;
            col_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            lin_q  <= lin_d;
            col_q  <= col_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign lin        = lin_q;
    assign col        = col_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_matriz_varredura_linhas.sv
module tb_matriz_varredura_linhas;

    localparam int TD = 4;
    localparam int ST = 2;
    localparam int R  = (1 + ST) * TD;   // cycles per row slot (blank + show)
    localparam int F  = 7 * R;           // cycles per frame

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [34:0] frame_in;
    logic [6:0]  lin;
    logic [4:0]  col;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    matriz_varredura_linhas #(
        .TICK_DIV   (TD),
        .SHOW_TICKS (ST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .frame_in   (frame_in),
        .lin        (lin),
        .col        (col),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [6:0] lin;
        logic [4:0] col;
        logic       busy;
        logic       fd;
    } obs_t;

    obs_t exp_q[$];
    int   fd_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: position within the current frame, counted in cycles.
    bit          m_run;
    int          m_pos;
    logic [34:0] m_shadow;
    obs_t        m_e;
    int          m_row;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run    = 1'b0;
            m_pos    = 0;
            m_shadow = '0;
            exp_q.delete();
        end else begin
            m_e = '0;
            if (m_run && (m_pos % R) >= TD) begin
                m_row    = m_pos / R;
                m_e.lin  = 7'(1 << m_row);
                m_e.col  = m_shadow[m_row*5 +: 5];
            end
            m_e.fd = m_run && (m_pos == F - 1);
            if (!m_run) begin
                if (enable) begin
                    m_run    = 1'b1;
                    m_pos    = 0;
                    m_shadow = frame_in;
                end
            end else if (m_pos == F - 1) begin
                if (enable) begin
                    m_pos    = 0;
                    m_shadow = frame_in;
                end else begin
                    m_run = 1'b0;
                end
            end else begin
                m_pos = m_pos + 1;
            end
            m_e.busy = m_run;
            exp_q.push_back(m_e);
        end
    end

    // Monitor: compare each registered output set against the scoreboard.
    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({lin, col, busy, frame_done} !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got lin=%b col=%b busy=%b fd=%b want lin=%b col=%b busy=%b fd=%b",
                         cyc, lin, col, busy, frame_done, e.lin, e.col, e.busy, e.fd);
            end
            checks++;
            if ($countones(lin) > 1) begin
                errors++;
                $display("FAIL lin_onehot cyc=%0d got lin=%b want at most one bit", cyc, lin);
            end
        end
        if (frame_done === 1'b1) fd_cyc.push_back(cyc);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    int          t0;
    int          t2;
    logic [4:0]  all1;
    logic [34:0] pat;

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        frame_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {lin, col, busy, frame_done}, '0);

        // Idle after reset with enable low.
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("idle_no_frame_done", fd_cyc.size(), 0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_lin_col", {lin, col}, '0);

        // Staircase frame, content swapped mid-frame, enable dropped in frame two.
        all1 = 5'h1F;
        for (int r = 0; r < 7; r++) pat[5*r +: 5] = all1 >> (r % 5);
        frame_in = pat;
        enable   = 1'b1;
        t0       = cyc;
        wait_until(t0 + 1 + 3*R + TD + 2);
        frame_in = '0;
        wait_until(t0 + 1 + F + 2*R + 6);
        enable = 1'b0;
        wait_until(t0 + 1 + 2*F + 3);
        chk("fd_count_two_frames", fd_cyc.size(), 2);
        if (fd_cyc.size() == 2) begin
            chk("fd_first_frame_cycle", fd_cyc[0], t0 + 1 + F);
            chk("fd_second_frame_cycle", fd_cyc[1], t0 + 1 + 2*F);
        end
        chk("idle_after_disable", busy, 1'b0);

        // Asynchronous reset during row 4, then restart with enable held.
        fd_cyc.delete();
        frame_in = {$urandom, $urandom};
        enable   = 1'b1;
        t0       = cyc;
        wait_until(t0 + 1 + 4*R + TD + 3);
        chk("row4_lit_before_reset", lin, 7'b0010000);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {lin, col, busy, frame_done}, '0);
        #1 rst_n = 1'b1;

        // Continuous scanning for three frames with frame_in churning every cycle.
        t2 = cyc;
        while (cyc < t2 + 1 + 3*F - 5) begin
            @(negedge clk);
            frame_in = {$urandom, $urandom};
        end
        enable = 1'b0;
        wait_until(t2 + 1 + 3*F + 5);
        chk("fd_count_three_frames", fd_cyc.size(), 3);
        for (int k = 0; k < fd_cyc.size() && k < 3; k++)
            chk("fd_period", fd_cyc[k], t2 + 1 + (k + 1)*F);
        chk("idle_after_three", busy, 1'b0);

        // Random enable toggling with random frames.
        for (int n = 0; n < 700; n++) begin
            @(negedge clk);
            enable   = ($urandom_range(0, 7) != 0);
            frame_in = {$urandom, $urandom};
        end
        enable = 1'b0;
        repeat (F + 5) @(negedge clk);
        chk("final_idle", {lin, col, busy}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
